// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the sram-like to AXI3 bridge.
// Holds the read/write FSM state encodings, the request latch payloads,
// the fixed AXI sideband values and the size/offset-to-byte-strobe helper.
package sram_axi_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    // Latched read request; src_data selects which port gets the response.
    typedef struct packed {
        logic              src_data;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
    } rd_req_t;

    // Latched data-port write request.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [DATA_W-1:0] wdata;
    } wr_req_t;

    // Single-beat incrementing transfers with no lock/cache/prot attributes.
    localparam logic [3:0] AXI_LEN   = 4'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic       AXI_WLAST = 1'b1;

    // Byte lanes touched by a write of the given size at the given byte offset.
    function automatic logic [STRB_W-1:0] size_to_wstrb(input logic [1:0] size,
                                                        input logic [1:0] offset);
        logic [STRB_W-1:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << offset;
            2'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges an instruction and a data sram-like port onto one AXI3 master.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_* / data_* request       sram-like requests (req, wr, size, addr, wdata)
//   inst_* / data_* response      rdata, addr_ok (same-cycle accept), data_ok
//   ar*/r*                        AXI read address / read data channels
//   aw*/w*/b*                     AXI write address / write data / response channels
// Reads (either port) share one read FSM; data writes use an independent write
// FSM. Data-port requests are serialised so data_data_ok stays in order.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // instruction sram-like port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    // data sram-like port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_t r_state, r_state_next;
    wr_state_t w_state, w_state_next;
    logic      aw_pend, aw_pend_next;
    logic      w_pend, w_pend_next;
    rd_req_t   r_req;
    wr_req_t   w_req;

    logic data_rd_busy;
    logic data_rd_acc;
    logic data_wr_acc;
    logic inst_rd_acc;

    // Single-beat responses carry no information beyond completion; errors are ignored.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, inst_wdata};

    // State registers for both FSMs and the AW/W pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
        end else begin
            r_state <= r_state_next;
            w_state <= w_state_next;
            aw_pend <= aw_pend_next;
            w_pend  <= w_pend_next;
        end
    end

    // Request latches, loaded on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= '0;
            w_req <= '0;
        end else begin
            if (data_rd_acc) begin
                r_req <= '{src_data: 1'b1, addr: data_addr, size: data_size};
            end else if (inst_rd_acc) begin
                r_req <= '{src_data: 1'b0, addr: inst_addr, size: inst_size};
            end
            if (data_wr_acc) begin
                w_req <= '{addr: data_addr, size: data_size, wdata: data_wdata};
            end
        end
    end

    // Acceptance arbitration and next-state logic for both FSMs.
    always_comb begin
        r_state_next = r_state;
        w_state_next = w_state;
        aw_pend_next = aw_pend;
        w_pend_next  = w_pend;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        // Any data transaction in flight blocks a new data request of either kind.
        data_rd_busy = (r_state != R_IDLE) && r_req.src_data;
        data_rd_acc  = !rst && (r_state == R_IDLE) && (w_state == W_IDLE)
                       && data_req && !data_wr;
        data_wr_acc  = !rst && (w_state == W_IDLE) && !data_rd_busy
                       && data_req && data_wr;
        // Inst reads yield to a data read only when that data read is actually taken.
        inst_rd_acc  = !rst && (r_state == R_IDLE) && inst_req && !inst_wr && !data_rd_acc;

        case (r_state)
            R_IDLE: begin
                if (data_rd_acc || inst_rd_acc) begin
                    r_state_next = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_state_next = R_R;
                end
            end
            R_R: begin
                if (rvalid) begin
                    r_state_next = R_IDLE;
                    if (r_req.src_data) begin
                        data_data_ok = !rst;
                    end else begin
                        inst_data_ok = !rst;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase

        case (w_state)
            W_IDLE: begin
                if (data_wr_acc) begin
                    w_state_next = W_REQ;
                    aw_pend_next = 1'b1;
                    w_pend_next  = 1'b1;
                end
            end
            W_REQ: begin
                // AW and W complete independently; move on once both are done.
                if (awready) begin
                    aw_pend_next = 1'b0;
                end
                if (wready) begin
                    w_pend_next = 1'b0;
                end
                if (!aw_pend_next && !w_pend_next) begin
                    w_state_next = W_B;
                end
            end
            W_B: begin
                if (bvalid) begin
                    w_state_next = W_IDLE;
                    data_data_ok = !rst;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign inst_addr_ok = inst_rd_acc;
    assign data_addr_ok = data_rd_acc || data_wr_acc;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = r_req.src_data ? DATA_ID : INST_ID;
    assign araddr  = r_req.addr;
    assign arlen   = AXI_LEN;
    assign arsize  = {1'b0, r_req.size};
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_R);

    assign awid    = DATA_ID;
    assign awaddr  = w_req.addr;
    assign awlen   = AXI_LEN;
    assign awsize  = {1'b0, w_req.size};
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign awvalid = aw_pend;

    assign wid     = DATA_ID;
    assign wdata   = w_req.wdata;
    assign wstrb   = size_to_wstrb(w_req.size, w_req.addr[1:0]);
    assign wlast   = AXI_WLAST;
    assign wvalid  = w_pend;
    assign bready  = (w_state == W_B);

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter INST_ID, default 4'd0: AXI ID driven on AR for instruction-port reads.
REQ-002 Parameter DATA_ID, default 4'd1: AXI ID driven on AR/AW for data-port transactions.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 inst_req/inst_wr/inst_size[1:0]/inst_addr[31:0]/inst_wdata[31:0]  in  instruction sram-like request.
REQ-007 inst_rdata[31:0]/inst_addr_ok/inst_data_ok  out  instruction sram-like response.
REQ-008 data_req/data_wr/data_size[1:0]/data_addr[31:0]/data_wdata[31:0]  in  data sram-like request.
REQ-009 data_rdata[31:0]/data_addr_ok/data_data_ok  out  data sram-like response.
REQ-010 arid[3:0] araddr[31:0] arlen[3:0] arsize[2:0] arburst[1:0] arlock[1:0] arcache[3:0] arprot[2:0] arvalid  out; arready  in.
REQ-011 rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid  in; rready  out.
REQ-012 awid[3:0] awaddr[31:0] awlen[3:0] awsize[2:0] awburst[1:0] awlock[1:0] awcache[3:0] awprot[2:0] awvalid  out; awready  in.
REQ-013 wid[3:0] wdata[31:0] wstrb[3:0] wlast wvalid  out; wready  in.
REQ-014 bid[3:0] bresp[1:0] bvalid  in; bready  out.

Function
REQ-015 Constants: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1, wid=DATA_ID; arsize/awsize = {1'b0, latched size}.
REQ-016 Read FSM SHALL have states R_IDLE, R_AR, R_R; write FSM SHALL have states W_IDLE, W_REQ, W_B.
REQ-017 In R_IDLE, a data read (data_req & !data_wr) SHALL win over an inst read (inst_req & !inst_wr) in the same cycle.
REQ-018 A data request (read or write) SHALL be accepted only when no data-port transaction is outstanding in either FSM, so data_data_ok is always in order.
REQ-019 A data write SHALL be accepted only in W_IDLE; a data read only in R_IDLE.
REQ-020 Acceptance SHALL assert the port's addr_ok combinationally in the same cycle and latch addr, size, wdata and source into registers.
REQ-021 inst_req with inst_wr=1 SHALL never receive inst_addr_ok.
REQ-022 R_IDLE->R_AR on accept; arvalid=1 in R_AR with latched araddr and arid; R_AR->R_R on arready.
REQ-023 rready=1 only in R_R; on rvalid, assert the latched source's data_ok for that cycle with its rdata=rdata, then R_R->R_IDLE.
REQ-024 In W_REQ, awvalid and wvalid SHALL drop independently on their handshakes; W_REQ->W_B once both have completed (same or different cycles).
REQ-025 bready=1 only in W_B; on bvalid, assert data_data_ok for one cycle, then W_B->W_IDLE.
REQ-026 wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size 2 -> 4'b1111; wdata passed unshifted.
REQ-027 An inst read and a data write MAY be accepted in the same cycle; inst_addr_ok and data_addr_ok both high.
REQ-028 rresp/bresp errors SHALL be ignored; the response completes normally.
REQ-029 Minimum read latency: addr_ok cycle N, arvalid N+1, data_ok = cycle rvalid is seen in R_R (N+2 earliest).

Reset
REQ-030 On rst both FSMs SHALL enter IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok and data_ok outputs SHALL be 0; latched registers SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it without any data_ok; the system-wide reset resets the AXI slave too.

Structure
REQ-032 A shared package SHALL hold the read/write state enums, the AXI constant values and the size/offset-to-wstrb function.
REQ-033 The block SHALL be a single module with no sub-modules.

Verification
REQ-034 Inst read 0xbfc00380 size 2, arready immediate, rvalid 1 cycle later with 0x3c1d0001 -> inst_addr_ok cycle 0, araddr 0xbfc00380 arid 0, inst_data_ok with inst_rdata 0x3c1d0001, arsize 2.
REQ-035 Simultaneous data and inst read -> data_addr_ok only; arid 1; inst_addr_ok after data_data_ok.
REQ-036 Data byte write addr 0x80000003 wdata 0x000000aa, awready 2 cycles before wready -> wstrb 4'b1000, awsize 0, single data_data_ok on bvalid.
REQ-037 Data write outstanding (bvalid withheld) plus new data read -> data_addr_ok held low until the data_data_ok cycle; inst read accepted meanwhile.
REQ-038 Half write addr 0x2 -> wstrb 4'b1100; inst_req with inst_wr=1 -> no inst_addr_ok for 20 cycles.
REQ-039 Assert rst while in R_R -> next cycle rready=0, arvalid=0, no data_ok; a fresh request is accepted immediately.
